inst_trace_fifo: RTL and testbench

INST_TRACE_FIFO -- requirements
Module: inst_trace_fifo

---
 rtl/cpu_trace_pkg.sv | 13 +
 rtl/trace_ram.sv | 22 ++
 rtl/inst_trace_fifo.sv | 105 ++++++++++
 tb/tb_inst_trace_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the instruction trace path.
package cpu_trace_pkg;

  localparam int unsigned TRACE_SEQ_W     = 16;
  localparam int unsigned TRACE_DEPTH_DEF = 16;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            inst;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port, no reset.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_trace_fifo.sv
// First-word-fall-through trace FIFO for retired instructions.
// Define TRACE_SEQ_EN to store and present a 16-bit per-entry sequence number.
module inst_trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH_DEF
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   cap_valid,
  input  logic [31:0]            cap_pc,
  input  logic [31:0]            cap_inst,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [15:0]            out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef TRACE_SEQ_EN
  localparam int unsigned ENTRY_W = 64 + TRACE_SEQ_W;
`else
  localparam int unsigned ENTRY_W = 64;
`endif

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      cnt;
  logic               ovf;
  logic               empty, full, pop, push;
  logic [ENTRY_W-1:0] wdata, rdata;
  trace_entry_t       head;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push  = cap_valid && (!full || pop);

  always_ff @(posedge clk_in) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (cap_valid && full && !pop) ovf <= 1'b1;
    end
  end

`ifdef TRACE_SEQ_EN
  logic [TRACE_SEQ_W-1:0] seq_cnt;

  always_ff @(posedge clk_in) begin
    if (reset || clear) seq_cnt <= '0;
    else if (push)      seq_cnt <= seq_cnt + TRACE_SEQ_W'(1);
  end

  assign wdata = {cap_pc, cap_inst, seq_cnt};
`else
  assign wdata = {cap_pc, cap_inst};
`endif

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ram (
    .clk   (clk_in),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_comb begin
    head = '0;
    if (!empty) begin
      head.pc   = rdata[ENTRY_W-1 -: 32];
      head.inst = rdata[ENTRY_W-33 -: 32];
`ifdef TRACE_SEQ_EN
      head.seq  = rdata[TRACE_SEQ_W-1:0];
`endif
    end
  end

  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_seq   = head.seq;
  assign count     = cnt;
  assign overflow  = ovf;

endmodule

// File: tb/tb_inst_trace_fifo.sv
// Directed bench for inst_trace_fifo (DEPTH=16), table vectors plus corner sequences.
module tb_inst_trace_fifo;

  logic        clk = 1'b0;
  logic        reset, cap_valid, clear, out_ready;
  logic [31:0] cap_pc, cap_inst;
  logic        out_valid, overflow;
  logic [31:0] out_pc, out_inst;
  logic [15:0] out_seq;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_trace_fifo #(.DEPTH(16)) dut (
    .clk_in    (clk),
    .reset     (reset),
    .cap_valid (cap_valid),
    .cap_pc    (cap_pc),
    .cap_inst  (cap_inst),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_seq   (out_seq),
    .count     (count),
    .overflow  (overflow)
  );

  function automatic logic [31:0] eseq(input int v);
`ifdef TRACE_SEQ_EN
    return 32'(v & 16'hFFFF);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head_chk(input string name, input logic [31:0] pc, input logic [31:0] inst,
                          input int seq);
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".pc"}, out_pc, pc);
    chk({name, ".inst"}, out_inst, inst);
    chk({name, ".seq"}, 32'(out_seq), eseq(seq));
  endtask

  task automatic idle_chk(input string name);
    chk({name, ".valid"}, 32'(out_valid), 32'd0);
    chk({name, ".pc"}, out_pc, 32'd0);
    chk({name, ".inst"}, out_inst, 32'd0);
    chk({name, ".seq"}, 32'(out_seq), 32'd0);
    chk({name, ".count"}, 32'(count), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; cap_valid = 1'b1; clear = 1'b0; out_ready = 1'b1;
    cap_pc = 32'hFFFF_FFFF; cap_inst = 32'hFFFF_FFFF;
    step();
    step();
    reset = 1'b0; cap_valid = 1'b0; out_ready = 1'b0;
  endtask

  // Pushes n entries with pc=0x1000+4i, inst=0x100+i, consumer stalled.
  task automatic fill(input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      cap_valid = 1'b1; cap_pc = 32'h1000 + 32'(4 * i); cap_inst = 32'h100 + 32'(i);
      step();
    end
    cap_valid = 1'b0;
  endtask

  typedef struct {
    logic        cv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        clr;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    int          eseqn;
    logic [4:0]  ecnt;
    logic        eov;
  } vec_t;

  vec_t vt[9];

  initial begin
    int pushed, popped;

    vt[0] = '{1, 32'h0040_0000, 32'h2001_0001, 0, 0, 1, 32'h0040_0000, 32'h2001_0001, 0, 1, 0};
    vt[1] = '{1, 32'h0040_0004, 32'h8c22_0004, 0, 0, 1, 32'h0040_0000, 32'h2001_0001, 0, 2, 0};
    vt[2] = '{0, 32'h0,         32'h0,         0, 1, 1, 32'h0040_0004, 32'h8c22_0004, 1, 1, 0};
    vt[3] = '{1, 32'h0040_0008, 32'hac23_0008, 0, 1, 1, 32'h0040_0008, 32'hac23_0008, 2, 1, 0};
    vt[4] = '{0, 32'h0,         32'h0,         0, 1, 0, 32'h0,         32'h0,         0, 0, 0};
    vt[5] = '{0, 32'h0,         32'h0,         0, 1, 0, 32'h0,         32'h0,         0, 0, 0};
    vt[6] = '{1, 32'h0040_000c, 32'h1000_ffff, 0, 1, 1, 32'h0040_000c, 32'h1000_ffff, 3, 1, 0};
    vt[7] = '{0, 32'h0,         32'h0,         1, 1, 0, 32'h0,         32'h0,         0, 0, 0};
    vt[8] = '{1, 32'h0040_0000, 32'h2001_0001, 0, 0, 1, 32'h0040_0000, 32'h2001_0001, 0, 1, 0};

    // Reset state, with captures and pops presented during reset.
    do_reset();
    idle_chk("rst");
    chk("rst.ovf", 32'(overflow), 32'd0);

    // Table vectors: basic push/pop/latency/clear behaviour.
    foreach (vt[i]) begin
      cap_valid = vt[i].cv; cap_pc = vt[i].pc; cap_inst = vt[i].inst;
      clear = vt[i].clr; out_ready = vt[i].rdy;
      step();
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d.pc", i), out_pc, vt[i].epc);
      chk($sformatf("vec%0d.inst", i), out_inst, vt[i].einst);
      chk($sformatf("vec%0d.seq", i), 32'(out_seq), eseq(vt[i].eseqn));
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].ecnt));
      chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vt[i].eov));
    end
    clear = 1'b0; cap_valid = 1'b0; out_ready = 1'b0;

    // Overflow: 17th push into a full FIFO is dropped.
    do_reset();
    fill(16);
    chk("full.count", 32'(count), 32'd16);
    chk("full.ovf", 32'(overflow), 32'd0);
    cap_valid = 1'b1; cap_pc = 32'hDEAD_0000; cap_inst = 32'hDEAD_BEEF;
    step();
    cap_valid = 1'b0;
    chk("ovf.count", 32'(count), 32'd16);
    chk("ovf.flag", 32'(overflow), 32'd1);
    head_chk("ovf.head", 32'h1000, 32'h100, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      head_chk($sformatf("ovf.drain%0d", i), 32'h1000 + 32'(4 * i), 32'h100 + 32'(i), i);
      step();
    end
    idle_chk("ovf.empty");
    chk("ovf.sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    fill(16);
    cap_valid = 1'b1; out_ready = 1'b1; cap_pc = 32'h5000; cap_inst = 32'h5;
    step();
    cap_valid = 1'b0;
    chk("fpp.count", 32'(count), 32'd16);
    chk("fpp.ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      head_chk($sformatf("fpp.drain%0d", i), 32'h1000 + 32'(4 * i), 32'h100 + 32'(i), i);
      step();
    end
    head_chk("fpp.new", 32'h5000, 32'h5, 16);
    step();
    idle_chk("fpp.empty");

    // 40 entries streamed through with intermittent pops; pointers wrap.
    do_reset();
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 300 && popped < 40; cyc++) begin
      cap_valid = (pushed < 40);
      cap_pc = 32'h2000 + 32'(4 * pushed); cap_inst = 32'h3000 + 32'(pushed);
      out_ready = (cyc % 3 != 0);
      if (out_ready && out_valid) begin
        head_chk($sformatf("wrap%0d", popped), 32'h2000 + 32'(4 * popped),
                 32'h3000 + 32'(popped), popped);
        popped++;
      end
      if (cap_valid) pushed++;
      step();
    end
    cap_valid = 1'b0; out_ready = 1'b0;
    chk("wrap.popped", 32'(popped), 32'd40);
    chk("wrap.count", 32'(count), 32'd0);
    chk("wrap.ovf", 32'(overflow), 32'd0);

    // Clear beats a simultaneous push with count=5 and overflow set.
    do_reset();
    fill(16);
    cap_valid = 1'b1; cap_pc = 32'hDEAD_0000;
    step();
    cap_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    out_ready = 1'b0;
    chk("clr.pre_count", 32'(count), 32'd5);
    chk("clr.pre_ovf", 32'(overflow), 32'd1);
    clear = 1'b1; cap_valid = 1'b1; cap_pc = 32'h7000; cap_inst = 32'h7;
    step();
    clear = 1'b0; cap_valid = 1'b0;
    idle_chk("clr");
    chk("clr.ovf", 32'(overflow), 32'd0);
    step();
    idle_chk("clr.hold");
    cap_valid = 1'b1; cap_pc = 32'h7100; cap_inst = 32'h71;
    step();
    cap_valid = 1'b0;
    head_chk("clr.next", 32'h7100, 32'h71, 0);
    chk("clr.next_count", 32'(count), 32'd1);

    // Reset mid-stream with count=7.
    do_reset();
    fill(7);
    chk("mrst.pre_count", 32'(count), 32'd7);
    reset = 1'b1; cap_valid = 1'b1; out_ready = 1'b1; clear = 1'b1;
    step();
    reset = 1'b0; cap_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    idle_chk("mrst");
    chk("mrst.ovf", 32'(overflow), 32'd0);
    cap_valid = 1'b1; cap_pc = 32'h8000; cap_inst = 32'h8;
    step();
    cap_valid = 1'b0;
    head_chk("mrst.next", 32'h8000, 32'h8, 0);
    chk("mrst.next_count", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
